// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encodings and default width for the serial arithmetic blocks
package serial_adder_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_fulladder.sv
// fulladder: combinational one-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder built on a single fulladder slice
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CW-1:0] cnt;
  logic carry, fa_sum, fa_carry, last;
  fulladder u_fa (
    .a(a_sr[0]),
    .b(b_sr[0]),
    .c(carry),
    .sum(fa_sum),
    .carry(fa_carry)
  );
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    state_nxt = state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
                state == ST_RUN  ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  // each new bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        a_sr   <= a;
        b_sr   <= b;
        carry  <= cin;
        cnt    <= '0;
        sum_sr <= '0;
      end else if (state == ST_RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        carry  <= fa_carry;
        cnt    <= cnt + CW'(1);
      end
    end
  end
  assign busy = state == ST_RUN;
  assign done = state == ST_DONE;
  assign sum  = sum_sr;
  assign cout = carry;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of the 8-bit serial adder
module tb_serial_adder;
  logic clk = 0, rst_n = 0, start = 0, cin = 0;
  logic [7:0] a = 0, b = 0;
  logic busy, done, cout;
  logic [7:0] sum;
  int passed = 0, total = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one start pulse and wait (bounded) for the done cycle
  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                    output logic [7:0] s, output logic c, output int nbusy,
                    output int lat, output bit ok, output bit overlap);
    a = ia; b = ib; cin = ic; start = 1;
    tick();
    start = 0;
    lat = 0; nbusy = 0; ok = 0; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1;
        overlap = busy;
        break;
      end
      if (busy) nbusy++;
      lat++;
      tick();
    end
    s = sum; c = cout;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    total++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      $display("FAIL reset: busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
    end else passed++;
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] s; logic c; int nb, lat; bit ok, ov;
    op(8'h0F, 8'h01, 1'b0, s, c, nb, lat, ok, ov);
    total++;
    if (!ok || s !== 8'h10 || c !== 1'b0) $display("FAIL basic_sum: ok=%0d sum=%h cout=%b want 10/0", ok, s, c);
    else passed++;
    total++;
    if (nb !== 8 || lat !== 8) $display("FAIL basic_latency: busy=%0d lat=%0d want 8/8", nb, lat);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_pulse: done=%b busy=%b want 0/0", done, busy);
    else passed++;
    a = 8'h77; b = 8'h66; cin = 1;
    repeat (3) tick();
    total++;
    if (sum !== 8'h10 || cout !== 1'b0) $display("FAIL basic_hold: sum=%h cout=%b want 10/0", sum, cout);
    else passed++;
  endtask

  task automatic test_vectors();
    logic [7:0] s; logic c; int nb, lat; bit ok, ov;
    op(8'hFF, 8'h01, 1'b0, s, c, nb, lat, ok, ov);
    total++;
    if (!ok || s !== 8'h00 || c !== 1'b1) $display("FAIL vec_ff_01: sum=%h cout=%b want 00/1", s, c);
    else passed++;
    tick();
    op(8'hFF, 8'hFF, 1'b1, s, c, nb, lat, ok, ov);
    total++;
    if (!ok || s !== 8'hFF || c !== 1'b1) $display("FAIL vec_ff_ff_1: sum=%h cout=%b want ff/1", s, c);
    else passed++;
    tick();
    op(8'h00, 8'h00, 1'b0, s, c, nb, lat, ok, ov);
    total++;
    if (!ok || s !== 8'h00 || c !== 1'b0) $display("FAIL vec_zero: sum=%h cout=%b want 00/0", s, c);
    else passed++;
    tick();
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [7:0] s = 8'hxx; logic c = 1'bx;
    a = 8'h3C; b = 8'h05; cin = 0; start = 1;
    tick();
    start = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin start = 1; a = 8'hAA; b = 8'h55; cin = 1; end
      if (i == 5) begin start = 0; a = 8'h00; b = 8'h00; cin = 0; end
      if (done) begin pulses++; s = sum; c = cout; end
      tick();
    end
    total++;
    if (pulses !== 1) $display("FAIL ignore_pulses: got %0d want 1", pulses);
    else passed++;
    total++;
    if (s !== 8'h41 || c !== 1'b0) $display("FAIL ignore_sum: sum=%h cout=%b want 41/0", s, c);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    a = 8'hF0; b = 8'h33; cin = 1; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    total++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      $display("FAIL midreset_clear: busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
    end else passed++;
    for (int i = 0; i < 16; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    total++;
    if (pulses !== 0) $display("FAIL midreset_quiet: active cycles=%0d want 0", pulses);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4] = '{8'h12, 8'hF0, 8'h80, 8'h7F};
    logic [7:0] vb [4] = '{8'h34, 8'h0F, 8'h80, 8'h01};
    logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] ve [4] = '{9'h046, 9'h100, 9'h100, 9'h081};
    int k = 0, last_t = -1, bad_gap = 0, bad_sum = 0, t = 0;
    a = va[0]; b = vb[0]; cin = vc[0]; start = 1;
    while (k < 4 && t < 100) begin
      tick();
      t++;
      if (done) begin
        if ({cout, sum} !== ve[k]) begin
          bad_sum++;
          $display("FAIL b2b_sum%0d: got %h want %h", k, {cout, sum}, ve[k]);
        end
        if (last_t >= 0 && t - last_t != 10) bad_gap++;
        last_t = t;
        k++;
        if (k < 4) begin a = va[k]; b = vb[k]; cin = vc[k]; end
        else start = 0;
      end
    end
    start = 0;
    total++;
    if (k !== 4) $display("FAIL b2b_count: done pulses %0d want 4", k);
    else passed++;
    total++;
    if (bad_sum !== 0) $display("FAIL b2b_sums: bad=%0d want 0", bad_sum);
    else passed++;
    total++;
    if (bad_gap !== 0) $display("FAIL b2b_gap: bad intervals=%0d want 0", bad_gap);
    else passed++;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [7:0] s, ra, rb; logic c, rc; int nb, lat; bit ok, ov;
    int bad = 0, bad_t = 0;
    logic [8:0] exp;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      op(ra, rb, rc, s, c, nb, lat, ok, ov);
      if (!ok || {c, s} !== exp) begin
        if (bad < 5) $display("FAIL rand_%0d: %h+%h+%b got %h want %h", n, ra, rb, rc, {c, s}, exp);
        bad++;
      end
      if (ov || lat != 8 || nb != 8) bad_t++;
      tick();
      if (done) bad_t++;
    end
    total++;
    if (bad !== 0) $display("FAIL rand_sum: mismatches=%0d want 0", bad);
    else passed++;
    total++;
    if (bad_t !== 0) $display("FAIL rand_timing: bad=%0d want 0", bad_t);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
